// File: rtl/melody_recorder_pkg.sv
// Shared definitions for the melody recorder and the playback sequencer:
// duration codes, rest pitch, FSM state encoding and entry packing.
package melody_recorder_pkg;

  localparam logic [5:0] DUR_16TH    = 6'd0;
  localparam logic [5:0] DUR_8TH     = 6'd1;
  localparam logic [5:0] DUR_QUARTER = 6'd2;
  localparam logic [5:0] DUR_HALF    = 6'd3;
  localparam logic [5:0] DUR_WHOLE   = 6'd4;
  localparam logic [5:0] DUR_DOT_8TH = 6'd5;

  localparam logic [7:0] REST_PITCH = 8'h80;
  localparam logic [4:0] UNIT_MAX   = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_NOTE  = 3'd2,
    ST_GAP   = 3'd3,
    ST_WRITE = 3'd4
  } rec_state_e;

  function automatic logic [15:0] make_entry(input logic [7:0] pitch, input logic [5:0] code);
    return {pitch, 2'b00, code};
  endfunction

endpackage

// File: rtl/melody_recorder_duration_quantizer.sv
// Combinational mapping from elapsed 16th-note units to a duration code.
module duration_quantizer
  import melody_recorder_pkg::*;
(
  input  logic [4:0] units,
  output logic [5:0] code
);

  always_comb begin
    if (units <= 5'd1) begin
      code = DUR_16TH;
    end else if (units == 5'd2) begin
      code = DUR_8TH;
    end else if (units == 5'd3) begin
      code = DUR_DOT_8TH;
    end else if (units <= 5'd5) begin
      code = DUR_QUARTER;
    end else if (units <= 5'd11) begin
      code = DUR_HALF;
    end else begin
      code = DUR_WHOLE;
    end
  end

endmodule

// File: rtl/melody_recorder.sv
// Live melody recorder: quantises held notes into RAM entries.
// Optional rest capture is enabled by defining RECORDER_REST_CAPTURE_EN.
module melody_recorder
  import melody_recorder_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_16TH = 12_500_000,
  parameter int unsigned MELODY_LENGTH   = 82,
  parameter int unsigned ADDR_WIDTH      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [31:0]           tempo_clocks,
  input  logic signed [7:0]     note_pitch_in,
  input  logic                  note_valid_in,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  recording,
  output logic [ADDR_WIDTH-1:0] rec_length,
  output logic                  full,
  output logic                  rec_done
);

  localparam logic [ADDR_WIDTH-1:0] LEN_MAX = ADDR_WIDTH'(MELODY_LENGTH);

  rec_state_e            state_q, state_d, ret_q, ret_d;
  logic signed [7:0]     pitch_q, pitch_d;
  logic [31:0]           tick_q, tick_d;
  logic [4:0]            unit_q, unit_d;
  logic                  en_q, en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  recording_q, recording_d;
  logic [ADDR_WIDTH-1:0] rec_length_q, rec_length_d;
  logic                  full_q, full_d;
  logic                  rec_done_q, rec_done_d;

  logic [31:0]           active_tempo_s;
  logic                  tick_wrap_s;
  logic [31:0]           tick_adv_s;
  logic [4:0]            unit_adv_s;
  logic [5:0]            code_s;
  logic                  pitch_change_s;
  logic                  note_end_s;
  logic                  rest_en_s;
  logic [ADDR_WIDTH-1:0] len_inc_s;

  assign active_tempo_s = (tempo_clocks == 32'd0) ? 32'(CLOCKS_PER_16TH) : tempo_clocks;
  assign tick_wrap_s    = (tick_q == (active_tempo_s - 32'd1));
  assign tick_adv_s     = tick_wrap_s ? 32'd0 : (tick_q + 32'd1);
  assign unit_adv_s     = (tick_wrap_s && (unit_q != UNIT_MAX)) ? (unit_q + 5'd1) : unit_q;
  assign pitch_change_s = note_valid_in && (note_pitch_in != pitch_q);
  assign note_end_s     = !note_valid_in || pitch_change_s;
  assign len_inc_s      = rec_length_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Durations are quantised from the count including the edge that ends the note.
  duration_quantizer u_quant (
    .units (unit_adv_s),
    .code  (code_s)
  );

`ifdef RECORDER_REST_CAPTURE_EN
  assign rest_en_s = (unit_adv_s != 5'd0);
`else
  assign rest_en_s = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    pitch_d      = pitch_q;
    tick_d       = tick_q;
    unit_d       = unit_q;
    en_d         = enable;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rec_length_d = rec_length_q;
    full_d       = full_q;
    rec_done_d   = 1'b0;

    case (state_q)
      // Arming needs a fresh enable edge so a full recording stays parked.
      ST_IDLE: begin
        if (enable && !en_q) begin
          state_d      = ST_ARMED;
          rec_length_d = '0;
          full_d       = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          rec_done_d = 1'b1;
        end else if (note_valid_in) begin
          state_d = ST_NOTE;
          pitch_d = note_pitch_in;
          tick_d  = 32'd0;
          unit_d  = 5'd0;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_NOTE: begin
        tick_d = tick_adv_s;
        unit_d = unit_adv_s;
        if (!enable || note_end_s) begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = rec_length_q;
          wr_data_d = make_entry(pitch_q, code_s);
          tick_d    = 32'd0;
          unit_d    = 5'd0;
          if (!enable) begin
            ret_d = ST_IDLE;
          end else if (pitch_change_s) begin
            ret_d   = ST_NOTE;
            pitch_d = note_pitch_in;
          end else begin
            ret_d = ST_GAP;
          end
        end else begin
          state_d = ST_NOTE;
        end
      end
      // Counting continues here so a back-to-back note loses no clock.
      ST_WRITE: begin
        tick_d       = tick_adv_s;
        unit_d       = unit_adv_s;
        rec_length_d = len_inc_s;
        if (len_inc_s == LEN_MAX) begin
          state_d    = ST_IDLE;
          full_d     = 1'b1;
          rec_done_d = 1'b1;
        end else if (ret_q == ST_IDLE) begin
          state_d    = ST_IDLE;
          rec_done_d = 1'b1;
        end else begin
          state_d = ret_q;
        end
      end
      ST_GAP: begin
        tick_d = tick_adv_s;
        unit_d = unit_adv_s;
        if (!enable || note_valid_in) begin
          pitch_d = note_pitch_in;
          tick_d  = 32'd0;
          unit_d  = 5'd0;
          if (rest_en_s) begin
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = rec_length_q;
            wr_data_d = make_entry(REST_PITCH, code_s);
            ret_d     = enable ? ST_NOTE : ST_IDLE;
          end else if (!enable) begin
            state_d    = ST_IDLE;
            rec_done_d = 1'b1;
          end else begin
            state_d = ST_NOTE;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    recording_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      pitch_q      <= 8'sd0;
      tick_q       <= 32'd0;
      unit_q       <= 5'd0;
      en_q         <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'h0000;
      recording_q  <= 1'b0;
      rec_length_q <= '0;
      full_q       <= 1'b0;
      rec_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      pitch_q      <= pitch_d;
      tick_q       <= tick_d;
      unit_q       <= unit_d;
      en_q         <= en_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      recording_q  <= recording_d;
      rec_length_q <= rec_length_d;
      full_q       <= full_d;
      rec_done_q   <= rec_done_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign recording  = recording_q;
  assign rec_length = rec_length_q;
  assign full       = full_q;
  assign rec_done   = rec_done_q;

endmodule

// File: tb/tb_melody_recorder.sv
// Directed self-checking bench for melody_recorder (MELODY_LENGTH=4, CLOCKS_PER_16TH=3).
module tb_melody_recorder;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [31:0]       tempo_clocks;
  logic signed [7:0] note_pitch_in;
  logic              note_valid_in;
  logic              wr_en;
  logic [6:0]        wr_addr;
  logic [15:0]       wr_data;
  logic              recording;
  logic [6:0]        rec_length;
  logic              full;
  logic              rec_done;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [6:0]  log_addr [0:31];
  logic [15:0] log_data [0:31];
  int          b;
  int          d;

  melody_recorder #(
    .CLOCKS_PER_16TH (3),
    .MELODY_LENGTH   (4),
    .ADDR_WIDTH      (7)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .tempo_clocks  (tempo_clocks),
    .note_pitch_in (note_pitch_in),
    .note_valid_in (note_valid_in),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .recording     (recording),
    .rec_length    (rec_length),
    .full          (full),
    .rec_done      (rec_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 32) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (rec_done) done_cnt = done_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
    chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
    chk({tag, "_recording"},  32'(recording),  32'd0);
    chk({tag, "_rec_length"}, 32'(rec_length), 32'd0);
    chk({tag, "_full"},       32'(full),       32'd0);
    chk({tag, "_rec_done"},   32'(rec_done),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; tempo_clocks = 32'd4;
    note_pitch_in = 8'sd0; note_valid_in = 1'b0;
    step(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(2);

    // Quarter note, ended by release together with enable low: one write.
    b = wr_cnt; d = done_cnt;
    enable = 1'b1; step(1);
    chk("armed_recording", 32'(recording), 32'd1);
    note_valid_in = 1'b1; note_pitch_in = 8'sd5; step(16);
    note_valid_in = 1'b0; enable = 1'b0; step(3);
    chk("q_count", 32'(wr_cnt - b), 32'd1);
    chk("q_addr", 32'(log_addr[b]), 32'd0);
    chk("q_data", 32'(log_data[b]), 32'h0502);
    chk("q_len", 32'(rec_length), 32'd1);
    chk("q_done", 32'(done_cnt - d), 32'd1);
    chk("q_idle", 32'(recording), 32'd0);
    step(2);

    // Pitch change while held: 8th then dotted 8th.
    b = wr_cnt;
    enable = 1'b1; step(1);
    note_valid_in = 1'b1; note_pitch_in = 8'sd3; step(8);
    note_pitch_in = 8'sd7; step(12);
    note_valid_in = 1'b0; enable = 1'b0; step(3);
    chk("pc_count", 32'(wr_cnt - b), 32'd2);
    chk("pc_data0", 32'(log_data[b]), 32'h0301);
    chk("pc_addr1", 32'(log_addr[b+1]), 32'd1);
    chk("pc_data1", 32'(log_data[b+1]), 32'h0705);
    chk("pc_len", 32'(rec_length), 32'd2);
    step(2);

    // Note, 24-clock gap, note.
    b = wr_cnt;
    enable = 1'b1; step(1);
    note_valid_in = 1'b1; note_pitch_in = 8'sd9; step(4);
    note_valid_in = 1'b0; step(24);
    note_valid_in = 1'b1; note_pitch_in = 8'sd2; step(4);
    note_valid_in = 1'b0; enable = 1'b0; step(3);
    chk("gap_data0", 32'(log_data[b]), 32'h0900);
`ifdef RECORDER_REST_CAPTURE_EN
    chk("gap_count", 32'(wr_cnt - b), 32'd3);
    chk("gap_rest", 32'(log_data[b+1]), 32'h8003);
    chk("gap_addr2", 32'(log_addr[b+2]), 32'd2);
    chk("gap_data2", 32'(log_data[b+2]), 32'h0200);
    chk("gap_len", 32'(rec_length), 32'd3);
`else
    chk("gap_count", 32'(wr_cnt - b), 32'd2);
    chk("gap_addr1", 32'(log_addr[b+1]), 32'd1);
    chk("gap_data1", 32'(log_data[b+1]), 32'h0200);
    chk("gap_len", 32'(rec_length), 32'd2);
`endif
    step(2);

    // Six short notes into a four-entry melody.
    b = wr_cnt; d = done_cnt;
    enable = 1'b1; step(1);
    for (int i = 0; i < 6; i++) begin
      note_valid_in = 1'b1; note_pitch_in = 8'(i + 1); step(2);
      note_valid_in = 1'b0; step(2);
    end
    step(3);
    chk("full_count", 32'(wr_cnt - b), 32'd4);
    chk("full_data0", 32'(log_data[b]), 32'h0100);
    chk("full_data3", 32'(log_data[b+3]), 32'h0400);
    chk("full_addr3", 32'(log_addr[b+3]), 32'd3);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_len", 32'(rec_length), 32'd4);
    chk("full_done", 32'(done_cnt - d), 32'd1);
    chk("full_idle", 32'(recording), 32'd0);
    enable = 1'b0; step(2);
    chk("full_hold", 32'(full), 32'd1);

    // Enable dropped 10 clocks into a held negative pitch.
    b = wr_cnt; d = done_cnt;
    enable = 1'b1; step(1);
    chk("rearm_full", 32'(full), 32'd0);
    chk("rearm_len", 32'(rec_length), 32'd0);
    note_valid_in = 1'b1; note_pitch_in = -8'sd16; step(10);
    enable = 1'b0; step(3);
    note_valid_in = 1'b0;
    chk("part_count", 32'(wr_cnt - b), 32'd1);
    chk("part_data", 32'(log_data[b]), 32'hF001);
    chk("part_done", 32'(done_cnt - d), 32'd1);
    chk("part_idle", 32'(recording), 32'd0);
    step(2);

    // tempo_clocks=0 selects CLOCKS_PER_16TH=3: 9 clocks -> 3 units.
    b = wr_cnt;
    tempo_clocks = 32'd0; enable = 1'b1; step(1);
    note_valid_in = 1'b1; note_pitch_in = 8'sh11; step(9);
    note_valid_in = 1'b0; enable = 1'b0; step(3);
    chk("t0_data", 32'(log_data[b]), 32'h1105);
    step(2);

    // tempo 1, 20 clocks: unit counter saturates -> whole.
    b = wr_cnt;
    tempo_clocks = 32'd1; enable = 1'b1; step(1);
    note_valid_in = 1'b1; note_pitch_in = 8'sh22; step(20);
    note_valid_in = 1'b0; enable = 1'b0; step(3);
    chk("sat_data", 32'(log_data[b]), 32'h2204);
    step(2);

    // Reset hitting the write cycle of a note.
    b = wr_cnt; d = done_cnt;
    tempo_clocks = 32'd4; enable = 1'b1; step(1);
    note_valid_in = 1'b1; note_pitch_in = 8'sd5; step(5);
    note_valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0; enable = 1'b0;
    step(1);
    chk_reset_vals("midrst");
    step(1);
    rst_n = 1'b1;
    step(10);
    chk("midrst_nowrite", 32'(wr_cnt - b), 32'd0);
    chk("midrst_nodone", 32'(done_cnt - d), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/melody_recorder.md
MELODY_RECORDER -- requirements
Module: melody_recorder

Interface
REQ-001 SHALL have parameter CLOCKS_PER_16TH, default 12_500_000, meaning clocks per 16th note when tempo_clocks is 0.
REQ-002 SHALL have parameter MELODY_LENGTH, default 82, meaning capacity in note entries.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, meaning melody RAM address width.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, which arms recording while high.
REQ-007 SHALL have port tempo_clocks, input, 32, giving clocks per 16th note; 0 selects CLOCKS_PER_16TH.
REQ-008 SHALL have port note_pitch_in, input, 8 signed, the live pitch.
REQ-009 SHALL have port note_valid_in, input, 1, high while a note is held.
REQ-010 SHALL have port wr_en, input-side RAM write strobe, output, 1, a one-cycle write pulse.
REQ-011 SHALL have port wr_addr, output, ADDR_WIDTH, the RAM write address.
REQ-012 SHALL have port wr_data, output, 16, the entry: [15:8] pitch, [7:6] 0, [5:0] duration code.
REQ-013 SHALL have port recording, output, 1, high while not IDLE.
REQ-014 SHALL have port rec_length, output, ADDR_WIDTH, the number of entries written.
REQ-015 SHALL have port full, output, 1, a level that is high once MELODY_LENGTH entries are written.
REQ-016 SHALL have port rec_done, output, 1, a one-cycle pulse when a recording ends.

Function
REQ-017 SHALL implement the states IDLE, ARMED, NOTE, GAP and WRITE.
REQ-018 IDLE SHALL go to ARMED on enable, clearing rec_length and full; leading silence in ARMED SHALL never be recorded.
REQ-019 ARMED SHALL go to NOTE on note_valid_in, latching note_pitch_in and zeroing the unit and tick counters.
REQ-020 The tick counter SHALL count to active_tempo-1 and then increment the unit counter, which saturates at 16.
REQ-021 A note SHALL end on note_valid_in falling or on note_pitch_in differing from the latched pitch while valid.
REQ-022 When a note ends, the FSM SHALL enter WRITE; wr_en SHALL pulse in the following cycle with wr_addr=rec_length, then rec_length SHALL increment.
REQ-023 Quantisation SHALL map units u to codes: u<=1 -> 0 (16th); u=2 -> 1 (8th); u=3 -> 5 (dotted 8th); u=4..5 -> 2 (quarter); u=6..11 -> 3 (half); u>=12 -> 4 (whole).
REQ-024 After a pitch-change end, the new pitch SHALL be latched and counting SHALL restart in the same cycle as wr_en, so no clock is lost.
REQ-025 After a valid-falling end, the FSM SHALL enter GAP.
REQ-026 In GAP, note_valid_in high SHALL go to NOTE per REQ-019.
REQ-027 When rec_length reaches MELODY_LENGTH, full SHALL assert, the FSM SHALL go to IDLE, rec_done SHALL pulse, and further notes SHALL be ignored.
REQ-028 enable low in NOTE SHALL write the partial note, then go to IDLE and pulse rec_done.
REQ-029 enable low in ARMED or GAP SHALL go to IDLE and pulse rec_done with no write.
REQ-030 Simultaneous enable-low and note end SHALL produce exactly one write.
REQ-031 wr_en SHALL never assert when full is high.

Reset
REQ-032 Reset SHALL drive state IDLE, wr_en=0, wr_addr=0, wr_data=0, recording=0, rec_length=0, full=0, rec_done=0, and all counters to 0.
REQ-033 Reset asserted mid-write SHALL suppress the pending write.

Configuration
REQ-034 With RECORDER_REST_CAPTURE_EN defined, a GAP of u>=1 units ending on a new note or on enable low SHALL write a rest entry {8'h80, code}, with gaps of u=0 discarded.
REQ-035 Without RECORDER_REST_CAPTURE_EN, GAP SHALL only wait and SHALL never write.

Structure
REQ-036 A shared package SHALL hold the duration code constants (0-5), the REST pitch 8'h80, and the state encoding, all shared with the playback sequencer.
REQ-037 The single sub-module SHALL be duration_quantizer, combinational, mapping units to a 6-bit code.

Verification
REQ-038 tempo_clocks=4, pitch 5 held 16 clocks then released -> one write, addr 0, data 16'h0502.
REQ-039 Pitch 3 held 8 clocks then changed to 7 while valid, held 12 clocks -> data 16'h0301, then 16'h0705 at addr 1.
REQ-040 With the macro, a note, a 24-clock gap, then a note at tempo 4 -> the middle entry is 16'h8003; without the macro, no middle entry.
REQ-041 MELODY_LENGTH=4, six short notes -> exactly 4 writes, full=1, rec_done pulses once, rec_length=4.
REQ-042 enable dropped 10 clocks into a note at tempo 4 -> partial write with code 1 (u=2), then IDLE and rec_done.
REQ-043 rst_n pulsed low during NOTE -> all outputs at reset values and no wr_en afterwards.
